// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width/sign codes, the FSM
// state type and the access legality check.
package lsu_pkg;

    // funct3 width/sign codes (stores use the low three as SB/SH/SW)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } lsu_state_e;

    // True when funct3 is a valid code for this direction and the address is
    // naturally aligned for the access width.
    function automatic logic is_legal_access(input logic [2:0] funct3,
                                             input logic       wren,
                                             input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~wren;
            F3_HU:   ok = ~wren & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side and memory-side signal bundle of the load/store unit.
//   slave  : view used by lsu_mem_ctrl (takes core requests and memory
//            responses, drives stall/load result and the memory request).
//   master : view used by whatever drives the core and memory sides.
interface lsu_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    // core side
    logic              i_lsu_req;
    logic              i_lsu_wren;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_st_data;
    logic [2:0]        i_funct3;
    logic              o_stall;
    logic [31:0]       o_ld_data;
    logic              o_ld_valid;
    logic              o_lsu_fault;
    logic              o_bus_err;
    // memory side
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic              i_mem_ack;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_lsu_req, i_lsu_wren, i_addr, i_st_data, i_funct3, i_mem_ack, i_mem_rdata,
        output o_stall, o_ld_data, o_ld_valid, o_lsu_fault, o_bus_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

    modport master (
        output i_lsu_req, i_lsu_wren, i_addr, i_st_data, i_funct3, i_mem_ack, i_mem_rdata,
        input  o_stall, o_ld_data, o_ld_valid, o_lsu_fault, o_bus_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

endinterface

// File: rtl/lsu_load_fmt.sv
// Load result formatter: selects the addressed byte/half of a memory word and
// sign- or zero-extends it.
//   rdata   : raw word from memory
//   addr_lo : low two bits of the byte address
//   funct3  : load width/sign code
//   ld_data : extended 32-bit load result
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h0, shifted[7:0]};
            F3_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between execute and a variable-latency data memory bus.
// Issues one bus transaction per legal request, stalls the core until the
// memory acks (or a timeout fires), and returns the formatted load result.
//   i_clk   : clock, all state on the rising edge
//   i_reset : synchronous active-high reset
//   bus     : core request/response and memory bus signals (slave view)
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    lsu_mem_ctrl_if.slave  bus
);

    localparam int unsigned    CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       ld_data_q, ld_data_d;

    // Transaction latched at acceptance; drives the bus for the whole BUS phase.
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        f3_q;
    logic              wren_q;

    logic              req_legal;
    logic              accept;
    logic [31:0]       st_wdata;
    logic [3:0]        st_be;
    logic [31:0]       fmt_data;

    logic              stall, mem_req, ld_valid, lsu_fault, bus_err;

    assign req_legal = is_legal_access(bus.i_funct3, bus.i_lsu_wren, bus.i_addr[1:0]);

    // Store lane replication; loads carry no enables and no data.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        if (bus.i_lsu_wren) begin
            case (bus.i_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << bus.i_addr[1:0];
                    st_wdata = {4{bus.i_st_data[7:0]}};
                end
                2'b01: begin
                    st_be    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{bus.i_st_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = bus.i_st_data;
                end
            endcase
        end
    end

    lsu_load_fmt u_load_fmt (
        .rdata   (bus.i_mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (f3_q),
        .ld_data (fmt_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ld_data_d = ld_data_q;
        accept    = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        ld_valid  = 1'b0;
        lsu_fault = 1'b0;
        bus_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_lsu_req && !i_reset) begin
                    if (req_legal) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = BUS;
                    end else begin
                        lsu_fault = 1'b1;
                    end
                end
            end
            BUS: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (bus.i_mem_ack) begin
                    // ack beats a timeout landing in the same cycle
                    ld_data_d = fmt_data;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    err_d     = 1'b1;
                    ld_data_d = 32'h0;
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // a request seen here belongs to the committing instruction
                ld_valid = ~wren_q;
                bus_err  = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ld_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ld_data_q <= ld_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q    <= '0;
            addr_lo_q <= 2'b00;
            wdata_q   <= 32'h0;
            be_q      <= 4'b0000;
            f3_q      <= 3'b000;
            wren_q    <= 1'b0;
        end else if (accept) begin
            addr_q    <= {bus.i_addr[ADDR_W-1:2], 2'b00};
            addr_lo_q <= bus.i_addr[1:0];
            wdata_q   <= st_wdata;
            be_q      <= st_be;
            f3_q      <= bus.i_funct3;
            wren_q    <= bus.i_lsu_wren;
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_ld_data   = ld_data_q;
    assign bus.o_ld_valid  = ld_valid;
    assign bus.o_lsu_fault = lsu_fault;
    assign bus.o_bus_err   = bus_err;
    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_we    = wren_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed transactions expand into an expected
// per-cycle trace built from the access rules; one process compares the DUT
// outputs to that trace every cycle, with literal values pinned on key cases.
module tb_lsu_mem_ctrl;

    localparam int unsigned T_CYC = 4;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.TIMEOUT_CYC(T_CYC), .ADDR_W(32)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct {
        logic        stall, fault, ld_valid, bus_err, mem_req;
        logic        zero_all;
        logic        chk_bus, chk_wdata, mem_we;
        logic [31:0] mem_addr, mem_wdata;
        logic [3:0]  mem_be;
        logic        chk_ld;
        logic [31:0] ld_data;
        logic        lit_ld_on;
        logic [31:0] lit_ld;
        logic        lit_st_on;
        logic [3:0]  lit_be;
        logic [31:0] lit_wdata;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, want);
        end
    endtask

    // ---------------- access model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic wren, input logic [2:0] f3, input logic [31:0] addr);
        int sz = acc_size(f3);
        if (sz == 0) return 1'b0;
        if (f3[2] && (wren || sz == 4)) return 1'b0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int          sz = acc_size(f3);
        logic [31:0] mask, v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = (rdata >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] be_model(input logic [31:0] addr, input logic [2:0] f3);
        int b = ((1 << acc_size(f3)) - 1) << (addr % 4);
        return b[3:0];
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] d, input logic [2:0] f3);
        int          sz = acc_size(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input logic req, input logic wren, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic ack,
                         input logic [31:0] rdata, input exp_t e);
        bus.i_lsu_req   = req;
        bus.i_lsu_wren  = wren;
        bus.i_funct3    = f3;
        bus.i_addr      = addr;
        bus.i_st_data   = sd;
        bus.i_mem_ack   = ack;
        bus.i_mem_rdata = rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ack_at: BUS cycle (1-based) in which the memory acks; 0 means never.
    task automatic txn(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input int ack_at, input logic [31:0] rdata,
                       input logic lit_on, input logic [31:0] lit_val, input logic [3:0] lit_be);
        exp_t e;
        bit   ok = legal(wren, f3, addr);
        bit   acked;
        int   nbus;
        e = '{default: 0};
        e.stall = ok;
        e.fault = !ok;
        drive(1'b1, wren, f3, addr, sd, 1'b0, 32'h5A5A5A5A, e);
        if (!ok) begin
            e = '{default: 0};
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, e);
            return;
        end
        acked = (ack_at > 0) && (ack_at <= int'(T_CYC));
        nbus  = acked ? ack_at : int'(T_CYC);
        for (int c = 1; c <= nbus; c++) begin
            e = '{default: 0};
            e.stall     = 1'b1;
            e.mem_req   = 1'b1;
            e.chk_bus   = 1'b1;
            e.mem_we    = wren;
            e.mem_addr  = addr & ~32'd3;
            e.mem_be    = wren ? be_model(addr, f3) : 4'b0000;
            e.chk_wdata = wren;
            e.mem_wdata = wdata_model(sd, f3);
            e.lit_st_on = lit_on && wren;
            e.lit_be    = lit_be;
            e.lit_wdata = lit_val;
            drive(1'b1, wren, f3, addr, sd, acked && (c == nbus),
                  (c == nbus) ? rdata : ~rdata, e);
        end
        e = '{default: 0};
        e.ld_valid  = !wren;
        e.bus_err   = !acked;
        e.chk_ld    = !wren;
        e.ld_data   = acked ? ld_model(rdata, addr, f3) : 32'h0;
        e.lit_ld_on = lit_on && !wren;
        e.lit_ld    = lit_val;
        // request still up in DONE must be ignored
        drive(1'b1, wren, f3, addr, sd, 1'b0, rdata, e);
        e = '{default: 0};
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, e);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",     32'(bus.o_stall),     32'(e.stall));
            chk("lsu_fault", 32'(bus.o_lsu_fault), 32'(e.fault));
            chk("ld_valid",  32'(bus.o_ld_valid),  32'(e.ld_valid));
            chk("bus_err",   32'(bus.o_bus_err),   32'(e.bus_err));
            chk("mem_req",   32'(bus.o_mem_req),   32'(e.mem_req));
            if (e.zero_all) begin
                chk("rst_ld_data", bus.o_ld_data, 32'h0);
                chk("rst_mem_we", 32'(bus.o_mem_we), 32'h0);
                chk("rst_mem_addr", bus.o_mem_addr, 32'h0);
                chk("rst_mem_wdata", bus.o_mem_wdata, 32'h0);
                chk("rst_mem_be", 32'(bus.o_mem_be), 32'h0);
            end
            if (e.chk_bus) begin
                chk("mem_we", 32'(bus.o_mem_we), 32'(e.mem_we));
                chk("mem_addr", bus.o_mem_addr, e.mem_addr);
                chk("mem_be", 32'(bus.o_mem_be), 32'(e.mem_be));
            end
            if (e.chk_wdata) chk("mem_wdata", bus.o_mem_wdata, e.mem_wdata);
            if (e.lit_st_on) begin
                chk("lit_mem_be", 32'(bus.o_mem_be), 32'(e.lit_be));
                chk("lit_mem_wdata", bus.o_mem_wdata, e.lit_wdata);
            end
            if (e.chk_ld) chk("ld_data", bus.o_ld_data, e.ld_data);
            if (e.lit_ld_on) chk("lit_ld_data", bus.o_ld_data, e.lit_ld);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset           = 1'b1;
        bus.i_lsu_req   = 1'b0;
        bus.i_lsu_wren  = 1'b0;
        bus.i_funct3    = 3'b000;
        bus.i_addr      = 32'h0;
        bus.i_st_data   = 32'h0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        e = '{default: 0};
        e.zero_all = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, e);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, e);

        // loads
        txn(1'b0, LW,  32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'h0);
        txn(1'b0, LB,  32'h103, 32'h0, 1, 32'h80112233, 1'b1, 32'hFFFFFF80, 4'h0);
        txn(1'b0, LBU, 32'h103, 32'h0, 2, 32'h80112233, 1'b1, 32'h00000080, 4'h0);
        txn(1'b0, LH,  32'h102, 32'h0, 1, 32'h80112233, 1'b1, 32'hFFFF8011, 4'h0);
        txn(1'b0, LHU, 32'h102, 32'h0, 1, 32'h80112233, 1'b1, 32'h00008011, 4'h0);
        txn(1'b0, LH,  32'h100, 32'h0, 2, 32'h12347FFF, 1'b1, 32'h00007FFF, 4'h0);
        txn(1'b0, LB,  32'h101, 32'h0, 1, 32'h0000F700, 1'b1, 32'hFFFFFFF7, 4'h0);

        // stores
        txn(1'b1, LB, 32'h101, 32'h000000A5, 1, 32'h0, 1'b1, 32'hA5A5A5A5, 4'b0010);
        txn(1'b1, LH, 32'h102, 32'h1234BEEF, 2, 32'h0, 1'b1, 32'hBEEFBEEF, 4'b1100);
        txn(1'b1, LH, 32'h100, 32'h1234BEEF, 1, 32'h0, 1'b1, 32'hBEEFBEEF, 4'b0011);
        txn(1'b1, LW, 32'h104, 32'hCAFEF00D, 2, 32'h0, 1'b1, 32'hCAFEF00D, 4'b1111);

        // illegal accesses
        txn(1'b0, LW,     32'h102, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1'b1, LH,     32'h103, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1'b0, 3'b110, 32'h100, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1'b1, LBU,    32'h100, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);
        txn(1'b1, LHU,    32'h100, 32'h0, 1, 32'h0, 1'b0, 32'h0, 4'h0);

        // timeout, ack on the last allowed cycle, store timeout
        txn(1'b0, LW, 32'h300, 32'h0, 0, 32'h11111111, 1'b1, 32'h00000000, 4'h0);
        txn(1'b0, LW, 32'h304, 32'h0, 4, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 4'h0);
        txn(1'b1, LW, 32'h308, 32'h76543210, 0, 32'h0, 1'b0, 32'h0, 4'h0);

        // reset in the second BUS cycle, late ack afterwards
        e = '{default: 0};
        e.stall = 1'b1;
        drive(1'b1, 1'b0, LW, 32'h200, 32'h0, 1'b0, 32'h0, e);
        e = '{default: 0};
        e.stall    = 1'b1;
        e.mem_req  = 1'b1;
        e.chk_bus  = 1'b1;
        e.mem_addr = 32'h200;
        drive(1'b1, 1'b0, LW, 32'h200, 32'h0, 1'b0, 32'h0, e);
        reset = 1'b1;
        drive(1'b1, 1'b0, LW, 32'h200, 32'h0, 1'b0, 32'h0, e);
        reset = 1'b0;
        e = '{default: 0};
        e.zero_all = 1'b1;
        drive(1'b0, 1'b0, LW, 32'h200, 32'h0, 1'b1, 32'h12345678, e);
        drive(1'b0, 1'b0, LW, 32'h200, 32'h0, 1'b0, 32'h0, e);

        // normal operation after reset
        txn(1'b0, LW, 32'h200, 32'h0, 1, 32'h12345678, 1'b1, 32'h12345678, 4'h0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL trace_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
